// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - collects a serial bit stream into g_width-bit words on a valid/ready port
module bit_deserializer #(
  parameter int g_width     = 8,
  parameter bit g_msb_first = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic [g_width-1:0]         word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(g_width)-1:0] bit_count,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int cw = $clog2(g_width);
  localparam logic [cw-1:0] last_count = cw'(g_width - 1);

  typedef enum logic {
    st_empty,
    st_full
  } state_t;

  state_t             state, state_nxt;
  logic [g_width-1:0] shift_q, shift_nxt;
  logic [g_width-1:0] word_q;
  logic [cw-1:0]      count_q;
  logic               ovf_q;
  logic               complete;
  logic               load_word;
  logic               drop_word;

  // The completed word includes the bit sampled on the completing edge,
  // so the output register loads from the next-shift value, not shift_q.
  always_comb begin
    shift_nxt = shift_q;
    if (g_msb_first) begin
      shift_nxt = {shift_q[g_width-2:0], bit_in};
    end else begin
      shift_nxt = {bit_in, shift_q[g_width-1:1]};
    end
  end

  assign complete = bit_valid && (count_q == last_count);

  always_comb begin
    state_nxt = state;
    load_word = 1'b0;
    drop_word = 1'b0;
    case (state)
      st_empty: begin
        if (complete) begin
          load_word = 1'b1;
          state_nxt = st_full;
        end
      end
      st_full: begin
        if (complete) begin
          // Refill on the transfer edge keeps full-rate streaming bubble-free.
          if (word_ready) begin
            load_word = 1'b1;
          end else begin
            drop_word = 1'b1;
          end
        end else if (word_ready) begin
          state_nxt = st_empty;
        end
      end
      default: state_nxt = st_empty;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_empty;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (bit_valid) begin
      shift_q <= shift_nxt;
      count_q <= complete ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (load_word) begin
      word_q <= shift_nxt;
    end
  end

  // A drop in the same cycle as clear_ovf must leave the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop_word) begin
      ovf_q <= 1'b1;
    end else if (clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state == st_full);
  assign bit_count  = count_q;
  assign overflow   = ovf_q;

endmodule
